// File: rtl/divisor_issue_queue.sv
// Request FIFO and issue sequencer in front of the algorithmic divider.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-divisor requests locally instead of issuing them.
module divisor_issue_queue #(
  parameter int tamanyo = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [tamanyo-1:0] in_num,
  input  logic [tamanyo-1:0] in_den,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [tamanyo-1:0] out_coc,
  output logic [tamanyo-1:0] out_res,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_dz,
  output logic               div_start,
  output logic [tamanyo-1:0] div_num,
  output logic [tamanyo-1:0] div_den,
  input  logic [tamanyo-1:0] div_coc,
  input  logic [tamanyo-1:0] div_res,
  input  logic               div_done,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  logic [tamanyo-1:0] num_mem [DEPTH];
  logic [tamanyo-1:0] den_mem [DEPTH];
  logic [TAG_W-1:0]   tag_mem [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop, not_empty;
  logic [tamanyo-1:0] head_num, head_den;
  logic [TAG_W-1:0]   head_tag;

  state_t             state_q;
  logic               div_start_q, out_valid_q;
  logic [tamanyo-1:0] div_num_q, div_den_q, out_coc_q, out_res_q;
  logic [TAG_W-1:0]   tag_q, out_tag_q;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != FULL);
  assign push      = in_valid & in_ready;
  assign head_num  = num_mem[rd_ptr_q];
  assign head_den  = den_mem[rd_ptr_q];
  assign head_tag  = tag_mem[rd_ptr_q];

  // The in-flight request stays in the FIFO until its result is captured.
  always_comb begin
    pop = 1'b0;
    if (state_q == WAIT && div_done) pop = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
    if (state_q == IDLE && not_empty && head_den == '0) pop = 1'b1;
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      num_mem[wr_ptr_q] <= in_num;
      den_mem[wr_ptr_q] <= in_den;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  logic out_dz_q;
  assign out_dz = out_dz_q;
`else
  assign out_dz = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q     <= IDLE;
      div_start_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_coc_q   <= '0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      out_dz_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (not_empty) begin
`ifdef DIV_ZERO_BYPASS_EN
            if (head_den == '0) begin
              out_coc_q   <= '1;
              out_res_q   <= head_num;
              out_tag_q   <= head_tag;
              out_dz_q    <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else
`endif
            begin
              div_num_q   <= head_num;
              div_den_q   <= head_den;
              tag_q       <= head_tag;
              div_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            out_coc_q   <= div_coc;
            out_res_q   <= div_res;
            out_tag_q   <= tag_q;
`ifdef DIV_ZERO_BYPASS_EN
            out_dz_q    <= 1'b0;
`endif
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_start = div_start_q;
  assign div_num   = div_num_q;
  assign div_den   = div_den_q;
  assign out_valid = out_valid_q;
  assign out_coc   = out_coc_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign busy      = (state_q != IDLE) || not_empty;

endmodule

// File: tb/tb_divisor_issue_queue.sv
// Scoreboard bench for divisor_issue_queue with a behavioural divider stub.
// Zero-divisor expectations follow DIV_ZERO_BYPASS_EN when it is defined.
module tb_divisor_issue_queue;
  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 3;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLK, RSTa;
  logic          in_valid, in_ready, out_valid, out_ready, out_dz;
  logic [W-1:0]  in_num, in_den, out_coc, out_res;
  logic [TW-1:0] in_tag, out_tag;
  logic          div_start, div_done, busy;
  logic [W-1:0]  div_num, div_den, div_coc, div_res;
  logic          stub_done, stray_done;

  assign div_done = stub_done | stray_done;

  divisor_issue_queue #(.tamanyo(W), .DEPTH(4), .TAG_W(TW)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_coc(out_coc), .out_res(out_res),
    .out_tag(out_tag), .out_dz(out_dz),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_coc(div_coc), .div_res(div_res), .div_done(div_done), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [W-1:0]  coc;
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   starts = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stub: results are computed from div_num/div_den at Done time, so a
  // DUT that disturbs its operands mid-division shows up as a wrong result.
  logic stub_busy;
  int   stub_cnt;
  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      div_coc   <= '0;
      div_res   <= '0;
    end else begin
      stub_done <= 1'b0;
      if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_done <= 1'b1;
          if (div_den == '0) begin
            div_coc <= '1;
            div_res <= div_num;
          end else begin
            div_coc <= $signed(div_num) / $signed(div_den);
            div_res <= $signed(div_num) % $signed(div_den);
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end else if (div_start) begin
        stub_busy <= 1'b1;
        stub_cnt  <= LAT;
      end
    end
  end

  always @(negedge CLK) begin
    if (div_start) starts++;
    if (RSTa && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0h coc %0h expected no output", out_tag, out_coc);
      end else begin
        mon_e = sb.pop_front();
        chk("out_coc", out_coc, mon_e.coc);
        chk("out_res", out_res, mon_e.res);
        chk("out_tag", out_tag, mon_e.tag);
        chk("out_dz", out_dz, mon_e.dz);
      end
    end
  end

  task automatic push(input logic [W-1:0] n, input logic [W-1:0] d, input logic [TW-1:0] t,
                      input logic [W-1:0] ec, input logic [W-1:0] er, input logic edz);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    in_num = n; in_den = d; in_tag = t; in_valid = 1'b1;
    while (!acc && waited < 200) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back('{coc: ec, res: er, tag: t, dz: edz});
    else begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready stuck 0 expected accept of tag %0h", t);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  int s0;

  initial begin
    RSTa = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stray_done = 1'b0;
    in_num = '0; in_den = '0; in_tag = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_coc", out_coc, 0);
    chk("rst_div_num", div_num, 0);
    chk("rst_out_dz", out_dz, 0);
    @(negedge CLK);
    RSTa = 1'b1;
    @(posedge CLK);
    #1;

    // single request: one Start pulse
    out_ready = 1'b1;
    s0 = starts;
    push(32'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0);
    drain(100);
    chk("single_starts", starts - s0, 1);

    // signed operands
    push(-32'sd100, 32'd7, 4'd1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    push(32'd100, -32'sd7, 4'd2, 32'hFFFF_FFF2, 32'd2, 1'b0);
    drain(100);

    // stray Done while idle is ignored
    stray_done = 1'b1;
    @(posedge CLK);
    #1;
    stray_done = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("stray_out_valid", out_valid, 0);
    chk("stray_busy", busy, 0);

    // fill the FIFO with the consumer stalled
    out_ready = 1'b0;
    push(32'd50, 32'd5, 4'd0, 32'd10, 32'd0, 1'b0);
    push(32'd17, 32'd4, 4'd1, 32'd4, 32'd1, 1'b0);
    push(-32'sd9, 32'd2, 4'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    push(32'd1000, 32'd33, 4'd3, 32'd30, 32'd10, 1'b0);
    @(negedge CLK);
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    push(32'd7, 32'd9, 4'd4, 32'd0, 32'd7, 1'b0);
    drain(300);

    // result held for 20 cycles, no new issue meanwhile
    out_ready = 1'b0;
    push(32'd81, 32'd9, 4'd6, 32'd9, 32'd0, 1'b0);
    push(32'd23, 32'd5, 4'd7, 32'd4, 32'd3, 1'b0);
    s0 = 0;
    while (!out_valid && s0 < 50) begin
      @(posedge CLK);
      #1;
      s0++;
    end
    chk("hold_reached", out_valid, 1);
    s0 = starts;
    repeat (20) begin
      @(negedge CLK);
      chk("hold_valid", out_valid, 1);
      chk("hold_coc", out_coc, 9);
      chk("hold_tag", out_tag, 6);
    end
    chk("hold_no_start", starts - s0, 0);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    drain(100);
    chk("hold_next_issue", starts - s0, 1);

    // zero divisor
    s0 = starts;
    push(32'd9, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'd9, BYP);
    if (BYP) begin
      @(posedge CLK);
      #1;
      chk("dz_fast_valid", out_valid, 1);
    end
    drain(100);
    chk("dz_starts", starts - s0, BYP ? 0 : 1);

    // reset in WAIT with 3 entries: third push lands two edges after the first, when the FSM is in WAIT
    push(32'd10, 32'd2, 4'd9, 32'd5, 32'd0, 1'b0);
    push(32'd11, 32'd2, 4'd10, 32'd5, 32'd1, 1'b0);
    push(32'd12, 32'd2, 4'd11, 32'd6, 32'd0, 1'b0);
    chk("pre_rst_busy", busy, 1);
    RSTa = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;
    s0 = starts;
    repeat (30) @(posedge CLK);
    #1;
    chk("post_rst_no_start", starts - s0, 0);
    chk("post_rst_out_valid", out_valid, 0);

    // recovery
    push(32'd12, 32'd5, 4'd8, 32'd2, 32'd2, 1'b0);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
